// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code types, default width and decode/popcount helpers
package gray_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int MAXW = 32;
  typedef logic [WIDTH_DEF-1:0] gray_t;
  typedef logic [WIDTH_DEF-1:0] bin_t;
  function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
    gray2bin[MAXW-1] = g[MAXW-1];
    for (int i = MAXW - 2; i >= 0; i--) gray2bin[i] = gray2bin[i+1] ^ g[i];
  endfunction
  function automatic int unsigned popcount(input logic [MAXW-1:0] v);
    popcount = 0;
    for (int i = 0; i < MAXW; i++) popcount += 32'(v[i]);
  endfunction
endpackage

// File: rtl/gray_ind_fifo.sv
// gray_ind_fifo: DEPTH-entry FIFO; ports CLK, nRST, push, pop, din -> full, empty, head (0 when empty)
module gray_ind_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic wr, rd;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign rd = pop && !empty;
  // a pop on the same edge frees the slot a push into a full FIFO needs
  assign wr = push && (!full || rd);
  assign head = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      wr_ptr <= wr ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= rd ? rd_ptr + AW'(1) : rd_ptr;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge CLK)
    if (wr) mem[wr_ptr] <= din;
endmodule

// File: rtl/gray_value_indicator.sv
// gray_value_indicator: samples Gray counter, decodes to binary, queues changes, emits via ENA/RDY
// Ports: CLK, nRST (async low), gray_v/gray__RDY sample in, indication_value__ENA/_v out with
// indication_value__RDY, drop_count (saturating FIFO-full losses), check_err (sticky, only
// when GRAY_IND_CHECK_EN is defined; otherwise tied 0).
module gray_value_indicator
  import gray_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 4,
  parameter int CNTW = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] gray_v,
  input  logic             gray__RDY,
  output logic             indication_value__ENA,
  output logic [WIDTH-1:0] indication_value_v,
  input  logic             indication_value__RDY,
  output logic [CNTW-1:0]  drop_count,
  output logic             check_err
);
  logic [WIDTH-1:0] prev_gray, bin;
  logic prev_valid, push_req, full, empty, drop;
  assign bin = WIDTH'(gray2bin(MAXW'(gray_v)));
  assign push_req = gray__RDY && (!prev_valid || gray_v != prev_gray);
  assign indication_value__ENA = !empty && indication_value__RDY;
  assign drop = push_req && full && !indication_value__ENA;
  gray_ind_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .CLK(CLK),
    .nRST(nRST),
    .push(push_req),
    .pop(indication_value__ENA),
    .din(bin),
    .full(full),
    .empty(empty),
    .head(indication_value_v)
  );
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      prev_gray <= '0;
      prev_valid <= 1'b0;
      drop_count <= '0;
    end else begin
      prev_gray <= gray__RDY ? gray_v : prev_gray;
      prev_valid <= prev_valid | gray__RDY;
      drop_count <= drop_count + CNTW'(drop && !(&drop_count));
    end
`ifdef GRAY_IND_CHECK_EN
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) check_err <= 1'b0;
    else check_err <= check_err | (push_req && prev_valid && popcount(MAXW'(gray_v ^ prev_gray)) > 1);
`else
  assign check_err = 1'b0;
`endif
endmodule

// File: tb/tb_gray_value_indicator.sv
// tb_gray_value_indicator: directed self-checking bench for gray_value_indicator (WIDTH=4, DEPTH=4)
module tb_gray_value_indicator;
  logic clk = 1'b0, n_rst = 1'b0, g_rdy = 1'b0, i_rdy = 1'b0;
  logic [3:0] g = 4'd0, val;
  logic ena, err;
  logic [7:0] drops;
  int tests = 0, fails = 0, enas;
  always #5 clk = ~clk;
  gray_value_indicator #(.WIDTH(4), .DEPTH(4), .CNTW(8)) dut (
    .CLK(clk),
    .nRST(n_rst),
    .gray_v(g),
    .gray__RDY(g_rdy),
    .indication_value__ENA(ena),
    .indication_value_v(val),
    .indication_value__RDY(i_rdy),
    .drop_count(drops),
    .check_err(err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic emit(input string tag, input logic [3:0] exp);
    check({tag, "_ena"}, 32'(ena), 1);
    check({tag, "_val"}, 32'(val), 32'(exp));
  endtask
  logic [3:0] steps3 [6] = '{4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
  logic [3:0] steps4 [4] = '{4'b1101, 4'b1111, 4'b1110, 4'b1010};
  logic [3:0] exp4 [4] = '{4'd10, 4'd11, 4'd12, 4'd13};
  initial begin
    #2;
    check("rst_ena", 32'(ena), 0);
    check("rst_val", 32'(val), 0);
    check("rst_drop", 32'(drops), 0);
    check("rst_err", 32'(err), 0);
    tick();
    n_rst = 1'b1;
    i_rdy = 1'b1;
    g_rdy = 1'b1;
    g = 4'b0000; tick(); emit("t1_0", 4'd0);
    g = 4'b0001; tick(); emit("t1_1", 4'd1);
    g = 4'b0011; tick(); emit("t1_2", 4'd2);
    g = 4'b0010; tick(); emit("t1_3", 4'd3);
    tick();
    check("t1_idle", 32'(ena), 0);
    g = 4'b0011;
    enas = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ena) begin
        enas++;
        check("t2_val", 32'(val), 2);
      end
    end
    check("t2_count", 32'(enas), 1);
    i_rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      g = steps3[i];
      tick();
    end
    check("t3_drop", 32'(drops), 2);
    check("t3_hold", 32'(ena), 0);
    g_rdy = 1'b0;
    i_rdy = 1'b1;
    #1;
    emit("t3_3", 4'd3);
    tick(); emit("t3_4", 4'd4);
    tick(); emit("t3_5", 4'd5);
    tick(); emit("t3_6", 4'd6);
    tick();
    check("t3_empty", 32'(ena), 0);
    i_rdy = 1'b0;
    g_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      g = steps4[i];
      tick();
    end
    i_rdy = 1'b1;
    #1;
    emit("t4_head", 4'd9);
    g = 4'b1011;
    tick();
    g_rdy = 1'b0;
    check("t4_drop", 32'(drops), 2);
    for (int i = 0; i < 4; i++) begin
      emit("t4_ord", exp4[i]);
      tick();
    end
    check("t4_empty", 32'(ena), 0);
    g_rdy = 1'b1;
    g = 4'b1001; tick(); emit("t5_14", 4'd14);
    g = 4'b1000; tick(); emit("t5_15", 4'd15);
    g = 4'b0000; tick(); emit("t5_0", 4'd0);
    check("t5_err", 32'(err), 0);
    tick();
    i_rdy = 1'b0;
    g = 4'b0011; tick();
    g = 4'b0001; tick();
    g_rdy = 1'b0;
    tick();
`ifdef GRAY_IND_CHECK_EN
    check("t6_err", 32'(err), 1);
`else
    check("t6_err", 32'(err), 0);
`endif
    i_rdy = 1'b1;
    #1;
    emit("t6_head", 4'd2);
    #2;
    n_rst = 1'b0;
    #1;
    check("t6_rst_ena", 32'(ena), 0);
    check("t6_rst_val", 32'(val), 0);
    check("t6_rst_drop", 32'(drops), 0);
    check("t6_rst_err", 32'(err), 0);
    tick();
    n_rst = 1'b1;
    tick();
    check("t6_after", 32'(ena), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
